answer_checker: RTL
===================

// Module: answer_checker
//
// PURPOSE
// Consumer end of the 3-bit answer-select code produced from the up/down/center buttons.
// Runs a fixed quiz: compares each submitted code against a parameterised answer key, then
// flags correct/wrong for a hold window and advances to the next question. It accumulates
// a score and signals completion after the last question. Sits between the code generator
// and the LED/seven-segment display logic.
//
// PARAMETERS
// NUM_QUESTIONS       3       questions in the quiz, 1..7
// NUM_CHOICES         4       valid codes are 1..NUM_CHOICES; code 0 = "nothing selected"
// ANSWER_KEY          {3'd2,3'd4,3'd1}  packed key, question i at bits [3*i+2:3*i]
// RESULT_HOLD_CYCLES  4       clk cycles out_correct/out_wrong stay high, >=1
//
// PORTS
// clk                     in   1    system clock, all state on rising edge
// reset                   in   1    asynchronous, active-high; forces IDLE state
// start                   in   1    level; rising edge starts a quiz from IDLE or DONE
// submit                  in   1    level (center button); rising edge = submit answer
// in_answer_select_code   in   3    currently selected answer code
// out_question_index      out  3    current question, 0-based
// out_correct             out  1    high during hold window after a correct submit
// out_wrong               out  1    high during hold window after a wrong submit
// out_score               out  3    count of correct answers this quiz
// out_busy                out  1    high in ASK and RESULT states
// out_done                out  1    high in DONE state
//
// BEHAVIOUR
// - Reset (async): state=IDLE, all outputs 0, hold counter 0, edge-detect regs 0.
// - start and submit are rising-edge detected with a 1-flop history register.
//   A level held high since before reset release is not an edge.
// - States:
//   IDLE:   start edge -> ASK; question index=0, score=0.
//   ASK:    submit edge with code in 1..NUM_CHOICES -> RESULT.
//           Compare code with key[index] and register the result.
//           Match: out_correct=1, score+1. Mismatch: out_wrong=1.
//           Both take effect on the cycle after the edge; the hold counter loads
//           RESULT_HOLD_CYCLES-1.
//           A submit edge with code 0 or code > NUM_CHOICES is ignored; stay in ASK.
//   RESULT: the counter decrements each cycle.
//           At 0: clear correct/wrong.
//           If index==NUM_QUESTIONS-1 -> DONE; else index+1 -> ASK.
//           submit and start edges are ignored.
//   DONE:   out_done=1; score and index frozen at their final values.
//           A start edge -> ASK with index=0 and score=0.
// - out_correct and out_wrong are never high together. Each stays high for exactly
//   RESULT_HOLD_CYCLES cycles.
// - The code is sampled only in the cycle of the submit edge. Later changes do not
//   affect the result.
// - A start edge during ASK or RESULT is ignored; there is no mid-quiz restart.
// - out_score saturates at NUM_QUESTIONS and never wraps.
// - Asserting reset at any point, including mid-hold, returns to IDLE within the same
//   cycle. No pending result survives reset.
// - Simultaneous start and submit edges in IDLE: start wins, and the submit is discarded.
//
// TESTING
// 1. Reset, start edge, submit code 1 -> next cycle: out_correct=1 for 4 cycles,
//    out_score=1, then index 1.
// 2. At q1 submit code 3 (key 4) -> out_wrong=1 for 4 cycles, out_score unchanged, index 2.
// 3. Submit with code 0, then with code 5 -> no state change, no flag; a later submit of
//    code 2 at q2 -> correct.
// 4. Full pass with answers 1,4,2 -> out_done=1, out_score=3, out_busy=0.
//    Start edge -> index 0, score 0.
// 5. Assert reset on the 2nd hold cycle -> all outputs 0 immediately, state IDLE.
//    A submit edge then has no effect.
// 6. Hold submit high over 10 cycles -> exactly one evaluation.
//    Change the code during RESULT -> result unchanged.

Source files
------------

// File: rtl/answer_checker.sv
// -----------------------------------------------------------------------------
// answer_checker
// Quiz engine sitting behind the button answer-code generator. Each rising edge
// of `submit` during a question compares the selected code against a packed
// answer key, raises out_correct or out_wrong for RESULT_HOLD_CYCLES clocks,
// then moves on to the next question. A running score is kept, and out_done
// is raised once the last question has been shown.
//
// Ports
//   clk                    in   system clock, rising edge
//   reset                  in   asynchronous, active-high
//   start                  in   level; rising edge starts a quiz (IDLE/DONE)
//   submit                 in   level; rising edge submits the selected code
//   in_answer_select_code  in   [2:0] selected answer, 0 = nothing selected
//   out_question_index     out  [2:0] current question, 0-based
//   out_correct            out  result-hold flag after a correct submit
//   out_wrong              out  result-hold flag after a wrong submit
//   out_score              out  [2:0] correct answers this quiz
//   out_busy               out  high while a question or result is active
//   out_done               out  high once the quiz is finished
// -----------------------------------------------------------------------------
module answer_checker #(
  parameter int unsigned                NUM_QUESTIONS      = 3,
  parameter int unsigned                NUM_CHOICES        = 4,
  parameter logic [3*NUM_QUESTIONS-1:0] ANSWER_KEY         = {3'd2, 3'd4, 3'd1},
  parameter int unsigned                RESULT_HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       submit,
  input  logic [2:0] in_answer_select_code,
  output logic [2:0] out_question_index,
  output logic       out_correct,
  output logic       out_wrong,
  output logic [2:0] out_score,
  output logic       out_busy,
  output logic       out_done
);

  localparam int unsigned CW = (RESULT_HOLD_CYCLES > 1) ? $clog2(RESULT_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RESULT_HOLD_CYCLES - 1);
  localparam logic [2:0]    MAX_CODE  = 3'(NUM_CHOICES);
  localparam logic [2:0]    LAST_Q    = 3'(NUM_QUESTIONS - 1);
  localparam logic [2:0]    MAX_SCORE = 3'(NUM_QUESTIONS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASK    = 2'd1,
    S_RESULT = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e        state_q;
  logic [2:0]    index_q;
  logic [2:0]    score_q;
  logic          correct_q;
  logic          wrong_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] hold_q;

  logic          start_prev_q;
  logic          submit_prev_q;
  logic          armed_q;

  logic          start_edge_s;
  logic          submit_edge_s;
  logic          code_valid_s;
  logic          code_match_s;

  // Key entry for a question: question i lives at bits [3*i+2:3*i].
  function automatic logic [2:0] key_at(input logic [2:0] idx);
    logic [3*NUM_QUESTIONS-1:0] sh;
    sh = ANSWER_KEY >> ({2'b00, idx} * 5'd3);
    return sh[2:0];
  endfunction

  // Edge history. armed_q stays low for the first cycle after reset so that a
  // level already high when reset releases is loaded into history, not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev_q  <= 1'b0;
      submit_prev_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      start_prev_q  <= start;
      submit_prev_q <= submit;
      armed_q       <= 1'b1;
    end
  end

  assign start_edge_s  = armed_q & start & ~start_prev_q;
  assign submit_edge_s = armed_q & submit & ~submit_prev_q;
  assign code_valid_s  = (in_answer_select_code != 3'd0) && (in_answer_select_code <= MAX_CODE);
  assign code_match_s  = (in_answer_select_code == key_at(index_q));

  // Quiz FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      index_q   <= 3'd0;
      score_q   <= 3'd0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // Start wins over any simultaneous submit; the submit is simply not looked at here.
          if (start_edge_s) begin
            state_q <= S_ASK;
            index_q <= 3'd0;
            score_q <= 3'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_ASK: begin
          // Codes outside 1..NUM_CHOICES are treated as "no answer yet".
          if (submit_edge_s && code_valid_s) begin
            state_q <= S_RESULT;
            hold_q  <= HOLD_LOAD;
            if (code_match_s) begin
              correct_q <= 1'b1;
              if (score_q != MAX_SCORE) begin
                score_q <= score_q + 3'd1;
              end
            end else begin
              wrong_q <= 1'b1;
            end
          end
        end
        S_RESULT: begin
          if (hold_q == '0) begin
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            if (index_q == LAST_Q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ASK;
              index_q <= index_q + 3'd1;
            end
          end else begin
            hold_q <= hold_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q   <= S_IDLE;
          correct_q <= 1'b0;
          wrong_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign out_question_index = index_q;
  assign out_correct        = correct_q;
  assign out_wrong          = wrong_q;
  assign out_score          = score_q;
  assign out_busy           = busy_q;
  assign out_done           = done_q;

endmodule
